// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte requesters, the arbiter and the uart_transmitter.
// The arbiter takes the slave view; the requester/transmitter side takes the master view.
interface uart_tx_arbiter_if #(
   parameter int N = 4
) ();
   logic [N-1:0]   req;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   ack;
   logic [7:0]     tx_data;
   logic           tx_send;
   logic           tx_busy;
   logic           active;
   logic [2:0]     owner;
   logic           err_timeout;

   modport slave (
      input  req, req_data, tx_busy,
      output ack, tx_data, tx_send, active, owner, err_timeout
   );

   modport master (
      output req, req_data, tx_busy,
      input  ack, tx_data, tx_send, active, owner, err_timeout
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter between N byte requesters.
// Sequences IDLE -> SEND -> WAIT_BUSY -> WAIT_DONE and drops a byte if busy never rises.
module uart_tx_arbiter #(
   parameter int N            = 4,
   parameter int BUSY_TIMEOUT = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   uart_tx_arbiter_if.slave       bus
);
   localparam int CW = $clog2(BUSY_TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   state_t         r_state;
   logic [2:0]     r_rr;
   logic [2:0]     r_owner;
   logic [CW-1:0]  r_cnt;
   logic [N-1:0]   r_ack;
   logic [7:0]     r_tx_data;
   logic           r_tx_send;
   logic           r_active;
   logic           r_err;

   logic [2:0]     w_win;
   logic           w_any;

   // First set request scanning upward from the rr pointer, wrapping N-1 -> 0.
   always_comb begin
      int k;
      k     = 0;
      w_win = '0;
      w_any = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = (int'(r_rr) + i) % N;
         if (!w_any && bus.req[k]) begin
            w_any = 1'b1;
            w_win = 3'(k);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_rr      <= '0;
         r_owner   <= '0;
         r_cnt     <= '0;
         r_ack     <= '0;
         r_tx_data <= '0;
         r_tx_send <= 1'b0;
         r_active  <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_ack     <= '0;
         r_tx_send <= 1'b0;
         r_err     <= 1'b0;
         case (r_state)
            IDLE: begin
               // A transmitter still busy from an aborted transfer blocks new grants.
               if (!bus.tx_busy && w_any) begin
                  r_tx_data <= bus.req_data[8*w_win +: 8];
                  r_owner   <= w_win;
                  r_ack     <= {{(N-1){1'b0}}, 1'b1} << w_win;
                  r_tx_send <= 1'b1;
                  r_active  <= 1'b1;
                  r_state   <= SEND;
               end
            end
            SEND: begin
               r_rr    <= (r_owner == 3'(N-1)) ? 3'd0 : r_owner + 3'd1;
               r_cnt   <= '0;
               r_state <= WAIT_BUSY;
            end
            WAIT_BUSY: begin
               if (bus.tx_busy) begin
                  r_state <= WAIT_DONE;
               end else if (r_cnt == CW'(BUSY_TIMEOUT - 2)) begin
                  // Counter reaches BUSY_TIMEOUT-1 on this edge: abandon the byte.
                  r_cnt    <= r_cnt + 1'b1;
                  r_err    <= 1'b1;
                  r_active <= 1'b0;
                  r_state  <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            WAIT_DONE: begin
               if (!bus.tx_busy) begin
                  r_active <= 1'b0;
                  r_state  <= IDLE;
               end
            end
            default: begin
               r_active <= 1'b0;
               r_state  <= IDLE;
            end
         endcase
      end
   end

   assign bus.ack         = r_ack;
   assign bus.tx_data     = r_tx_data;
   assign bus.tx_send     = r_tx_send;
   assign bus.active      = r_active;
   assign bus.owner       = r_owner;
   assign bus.err_timeout = r_err;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table for arbitration order plus
// hand-written sequences for timeout, reset-while-busy and busy-at-reset-exit.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int BT = 16;

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;
   int   cyc_n;

   // Transmitter busy model: rises BM_DLY cycles after tx_send, held BM_LEN cycles.
   localparam int BM_DLY = 2;
   localparam int BM_LEN = 20;
   bit   bm_en;
   int   bm_wait;
   int   bm_hold;
   int   bm_fall_cyc;

   uart_tx_arbiter_if #(.N(N)) ifc ();

   uart_tx_arbiter #(.N(N), .BUSY_TIMEOUT(BT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (ifc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic [2:0] owner;
      logic [7:0] data;
   } vec_t;

   vec_t vt[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic bm_reset();
      bm_wait     = 0;
      bm_hold     = 0;
      bm_fall_cyc = -100;
   endtask

   // One clock: observe at the falling edge, then advance the busy model.
   task automatic cyc();
      @(negedge clk);
      cyc_n++;
      if (bm_en) begin
         if (ifc.tx_send) begin
            bm_wait = BM_DLY;
         end else if (bm_wait > 0) begin
            bm_wait--;
            if (bm_wait == 0) begin
               ifc.tx_busy = 1'b1;
               bm_hold     = BM_LEN;
            end
         end else if (bm_hold > 0) begin
            bm_hold--;
            if (bm_hold == 0) begin
               ifc.tx_busy = 1'b0;
               bm_fall_cyc = cyc_n;
            end
         end
      end
   endtask

   task automatic wait_idle(input string nm);
      int sends;
      int acks;
      int n;
      sends = 0;
      acks  = 0;
      n     = 0;
      do begin
         cyc();
         n++;
         if (ifc.tx_send) sends++;
         if (ifc.ack != 0) acks++;
      end while (ifc.active && n < 200);
      chk({nm, " active_fell"}, 32'(ifc.active), 32'd0);
      chk({nm, " extra_send"}, 32'(sends), 32'd0);
      chk({nm, " extra_ack"}, 32'(acks), 32'd0);
      chk({nm, " active_after_busy"}, 32'(cyc_n), 32'(bm_fall_cyc + 1));
   endtask

   task automatic do_byte(input string nm, input logic [3:0] r,
                          input logic [2:0] own, input logic [7:0] dat);
      int n;
      bm_reset();
      bm_en   = 1'b1;
      ifc.req = r;
      n = 0;
      do begin
         cyc();
         n++;
      end while (ifc.ack == 0 && n < 40);
      chk({nm, " latency"}, 32'(n), 32'd1);
      chk({nm, " ack"}, 32'(ifc.ack), 32'(4'b0001 << own));
      chk({nm, " owner"}, 32'(ifc.owner), 32'(own));
      chk({nm, " tx_data"}, 32'(ifc.tx_data), 32'(dat));
      chk({nm, " tx_send"}, 32'(ifc.tx_send), 32'd1);
      ifc.req = '0;
      wait_idle(nm);
   endtask

   task automatic chk_reset_vals(input string nm);
      chk({nm, " ack"}, 32'(ifc.ack), 32'd0);
      chk({nm, " tx_data"}, 32'(ifc.tx_data), 32'd0);
      chk({nm, " tx_send"}, 32'(ifc.tx_send), 32'd0);
      chk({nm, " active"}, 32'(ifc.active), 32'd0);
      chk({nm, " owner"}, 32'(ifc.owner), 32'd0);
      chk({nm, " err"}, 32'(ifc.err_timeout), 32'd0);
   endtask

   initial begin
      int n;
      int k;
      bit seen;
      n_chk = 0; n_fail = 0; cyc_n = 0;
      bm_en = 1'b0;
      bm_reset();
      reset = 1'b1;
      ifc.req      = '0;
      ifc.req_data = {8'h13, 8'h12, 8'h11, 8'h8E};
      ifc.tx_busy  = 1'b0;

      vt[0] = '{4'b1111, 3'd0, 8'h10};
      vt[1] = '{4'b1111, 3'd1, 8'h11};
      vt[2] = '{4'b1111, 3'd2, 8'h12};
      vt[3] = '{4'b1111, 3'd3, 8'h13};
      vt[4] = '{4'b0010, 3'd1, 8'h11};
      vt[5] = '{4'b0011, 3'd0, 8'h10};
      vt[6] = '{4'b0011, 3'd1, 8'h11};
      vt[7] = '{4'b0100, 3'd2, 8'h12};
      vt[8] = '{4'b1001, 3'd3, 8'h13};
      vt[9] = '{4'b1001, 3'd0, 8'h10};

      cyc(); cyc();
      chk_reset_vals("reset");
      reset = 1'b0;
      cyc();

      // Single byte from requester 0.
      do_byte("t1", 4'b0001, 3'd0, 8'h8E);

      // Reset clears the rr pointer before the table run.
      reset = 1'b1;
      ifc.req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      cyc();
      reset = 1'b0;
      cyc();
      for (int i = 0; i < 10; i++) begin
         do_byte($sformatf("vec%0d", i), vt[i].req, vt[i].owner, vt[i].data);
      end

      // Busy never rises: timeout, then a pending request is granted.
      bm_reset();
      bm_en = 1'b0;
      ifc.req = 4'b0010;
      cyc();
      chk("t4 ack", 32'(ifc.ack), 32'b0010);
      chk("t4 send", 32'(ifc.tx_send), 32'd1);
      ifc.req = 4'b0100;
      k = -1;
      for (int j = 1; j <= BT + 5; j++) begin
         cyc();
         if (ifc.err_timeout && k < 0) begin
            k = j;
            break;
         end
      end
      chk("t4 err_cycle", 32'(k), 32'(BT));
      chk("t4 active", 32'(ifc.active), 32'd0);
      bm_reset();
      bm_en = 1'b1;
      cyc();
      chk("t4 err_pulse", 32'(ifc.err_timeout), 32'd0);
      chk("t4 next_ack", 32'(ifc.ack), 32'b0100);
      chk("t4 next_owner", 32'(ifc.owner), 32'd2);
      chk("t4 next_data", 32'(ifc.tx_data), 32'h12);
      ifc.req = '0;
      wait_idle("t4 next");

      // Reset while in WAIT_DONE with busy held high.
      bm_reset();
      bm_en = 1'b1;
      ifc.req = 4'b0001;
      cyc();
      chk("t5 ack", 32'(ifc.ack), 32'b0001);
      ifc.req = '0;
      n = 0;
      while (!ifc.tx_busy && n < 20) begin
         cyc();
         n++;
      end
      cyc(); cyc(); cyc();
      chk("t5 busy_high", 32'(ifc.tx_busy), 32'd1);
      bm_en = 1'b0;
      reset = 1'b1;
      ifc.req = 4'b1000;
      cyc();
      chk_reset_vals("t5 reset");
      reset = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < 4; j++) begin
         cyc();
         if (ifc.ack != 0) seen = 1'b1;
      end
      chk("t5 no_ack_busy", 32'(seen), 32'd0);
      ifc.tx_busy = 1'b0;
      bm_reset();
      bm_en = 1'b1;
      cyc();
      chk("t5 ack_after", 32'(ifc.ack), 32'b1000);
      chk("t5 owner", 32'(ifc.owner), 32'd3);
      ifc.req = '0;
      wait_idle("t5 after");

      // Busy already high as reset is released.
      bm_en = 1'b0;
      bm_reset();
      ifc.tx_busy = 1'b1;
      reset = 1'b1;
      ifc.req = 4'b0100;
      cyc(); cyc();
      reset = 1'b0;
      seen = 1'b0;
      for (int j = 0; j < 3; j++) begin
         cyc();
         if (ifc.ack != 0) seen = 1'b1;
      end
      chk("t6 no_ack_busy", 32'(seen), 32'd0);
      ifc.tx_busy = 1'b0;
      bm_en = 1'b1;
      cyc();
      chk("t6 ack", 32'(ifc.ack), 32'b0100);
      chk("t6 owner", 32'(ifc.owner), 32'd2);
      chk("t6 data", 32'(ifc.tx_data), 32'h12);
      ifc.req = '0;
      wait_idle("t6");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_transmitter between N byte-producing requesters (for example a debounced-button test source, a status reporter and a loopback echo).
Each requester presents a byte and holds a request until it receives a one-cycle acknowledge. The arbiter latches the winning byte, drives the transmitter's data/send inputs and sequences on its busy output. It sits between the requesters and the uart_transmitter instance in a top-level module.

Parameters:
N, 4, number of requesters (2..8)
BUSY_TIMEOUT, 16, max cycles to wait for tx_busy to rise after tx_send before abandoning the byte (>=2)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state on the clk edge where sampled high
req  input  N  per-requester level request; held until matching ack
req_data  input  8*N  requester i byte at bits [8*i+7:8*i]
ack  output  N  one-hot one-cycle pulse: byte of requester i latched
tx_data  output  8  to uart_transmitter data
tx_send  output  1  to uart_transmitter send; one-cycle pulse
tx_busy  input  1  from uart_transmitter busy
active  output  1  high whenever state != IDLE
owner  output  3  index of requester currently served (valid while active)
err_timeout  output  1  one-cycle pulse when BUSY_TIMEOUT expires

Behaviour:
- Reset values: ack=0, tx_data=0, tx_send=0, active=0, owner=0, err_timeout=0, state=IDLE, rr pointer=0, timeout counter=0.
- Reset mid-transfer aborts immediately. The arbiter does not wait for tx_busy; the transmitter is reset by its own path.
- State machine: IDLE -> SEND -> WAIT_BUSY -> WAIT_DONE -> IDLE.
- IDLE:
  - If tx_busy=1, stay in IDLE. The transmitter may still be busy from a prior aborted transfer.
  - Else if any req bit is set, pick the winner as the first set bit scanning upward from rr pointer, with wrap-around from N-1 to 0.
  - Register tx_data=req_data[winner], owner=winner, ack[winner]=1 for exactly this transition cycle, then go to SEND.
  - Grant latency: ack is high on the first edge at which req is seen with the arbiter idle and tx_busy=0.
- SEND:
  - tx_send=1 for exactly one cycle.
  - rr pointer <= (owner+1) mod N.
  - Clear the timeout counter and go to WAIT_BUSY.
- WAIT_BUSY:
  - If tx_busy=1, go to WAIT_DONE.
  - Else increment the counter. When the counter reaches BUSY_TIMEOUT-1, pulse err_timeout for one cycle and go to IDLE; the byte is dropped, not retried.
- WAIT_DONE:
  - Stay while tx_busy=1. When tx_busy=0, go to IDLE.
  - A new grant can occur on the following edge, giving a minimum inter-byte gap of one idle cycle.
- tx_data is held stable from the SEND state until the next grant.
- Requester rules:
  - A requester must deassert req, or change req_data to its next byte, in the cycle after ack.
  - A requester that keeps req high after ack is treated as a new request (back-to-back bytes).
  - The arbiter never acks a requester whose req is low in the sampling cycle.
- Fairness: with all N requesting continuously, grants cycle 0,1,..,N-1,0. No requester waits more than N-1 other bytes.
- Simultaneous events:
  - req rising in the same cycle tx_busy falls (in WAIT_DONE) is granted on the next IDLE cycle.
  - req dropping while in IDLE before arbitration is simply not granted.
- The winner index is computed combinationally from the req snapshot and rr pointer. Width of owner is fixed at 3; upper bits are 0 when N<8.

Test Plan:
1. Reset, then req=4'b0001 with data0=8'h8E, tx_busy model rising 2 cycles after send and staying high 20 cycles → ack=0001 once; tx_send pulses once; tx_data=8'h8E; active falls the cycle after busy falls.
2. req=4'b1111 held with data i = 8'h10+i, 4 bytes → owner sequence 0,1,2,3 and tx_data sequence 10,11,12,13; exactly one ack per byte; never two tx_send pulses without an intervening busy high.
3. rr pointer at 2 (after serving 1), req=4'b0011 → requester 0 granted before 1 (wrap-around); then 1.
4. tx_busy held low after tx_send → err_timeout pulses exactly BUSY_TIMEOUT cycles after the SEND cycle; active returns to 0; next pending req is granted normally.
5. Assert reset during WAIT_DONE while tx_busy=1 → all outputs return to reset values next edge; with req pending, no ack until tx_busy drops.
6. tx_busy=1 at the exit of reset with req=4'b0100 → no ack while busy; ack=0100 on the first edge after busy falls.
